// File: rtl/ahb_slave_mem_pkg.sv
// Shared AHB-Lite encodings and slave FSM state type for the slave memory model.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_W4    = 3'd4,
        HSIZE_W8    = 3'd5,
        HSIZE_W16   = 3'd6,
        HSIZE_W32   = 3'd7
    } hsize_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slv_state_e;

    // Beat count of a wrapping burst; 0 for every non-wrapping type.
    function automatic logic [4:0] wrap_beats(input hburst_e burst);
        case (burst)
            HBURST_WRAP4:  return 5'd4;
            HBURST_WRAP8:  return 5'd8;
            HBURST_WRAP16: return 5'd16;
            default:       return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite transfer and response signals between a master and the slave memory.
interface ahb_slave_mem_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] haddr;
    logic [31:0]       hwdata;
    logic [2:0]        hburst;
    logic [2:0]        hsize;
    logic [1:0]        htrans;
    logic              hwrite;
    logic              hready;
    logic [31:0]       hrdata;
    logic              hresp;

    modport master (
        output haddr, hwdata, hburst, hsize, htrans, hwrite,
        input  hready, hrdata, hresp
    );

    modport slave (
        input  haddr, hwdata, hburst, hsize, htrans, hwrite,
        output hready, hrdata, hresp
    );
endinterface

// File: rtl/ahb_slave_mem_lane_dec.sv
// Little-endian byte-strobe decode from transfer size and address LSBs,
// with a misalignment flag for half/word transfers.
module ahb_slv_lane_dec
    import ahb_pkg::*;
(
    input  logic [2:0] hsize_i,
    input  logic [1:0] addr_i,
    output logic [3:0] strb_o,
    output logic       misalign_o
);

    always_comb begin
        strb_o     = 4'b0000;
        misalign_o = 1'b0;
        case (hsize_i)
            HSIZE_BYTE: strb_o = 4'b0001 << addr_i;
            HSIZE_HALF: begin
                strb_o     = addr_i[1] ? 4'b1100 : 4'b0011;
                misalign_o = addr_i[0];
            end
            HSIZE_WORD: begin
                strb_o     = 4'b1111;
                misalign_o = |addr_i;
            end
            default: begin
                strb_o     = 4'b0000;
                misalign_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave SRAM with wait states, two-cycle ERROR and address/data pipelining.
// Define AHB_SLV_BURST_CHECK_EN to flag SEQ beats whose address breaks the burst sequence.
//
//   state | meaning
//   IDLE  | no data phase; hready=1, OKAY
//   WAIT  | inserted wait cycles of an OKAY data phase; hready=0
//   DATA  | final data-phase cycle; write commits / read data driven
//   ERR1  | first ERROR cycle; hready=0, hresp=1
//   ERR2  | second ERROR cycle; hready=1, hresp=1
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int MEM_BYTES   = 1024,
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 32
) (
    input logic            hclk,
    input logic            hrst,
    ahb_slave_mem_if.slave bus
);

    localparam int         WORDS   = MEM_BYTES / 4;
    localparam int         MEM_AW  = $clog2(MEM_BYTES);
    localparam int         IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    slv_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       strb_q, strb_d;
    logic             write_q, write_d;

    logic [31:0]      mem_q [WORDS];

    logic             hready_int;
    hresp_e           hresp_int;
    logic             accept;
    logic             addr_err;
    logic             size_err;
    logic             misalign;
    logic             burst_err;
    logic             xfer_err;
    logic [3:0]       strb;

    ahb_slv_lane_dec u_lane_dec (
        .hsize_i    (bus.hsize),
        .addr_i     (bus.haddr[1:0]),
        .strb_o     (strb),
        .misalign_o (misalign)
    );

    assign addr_err = (bus.haddr >> MEM_AW) != '0;
    assign size_err = bus.hsize > 3'd2;
    assign xfer_err = addr_err | size_err | misalign | burst_err;

`ifdef AHB_SLV_BURST_CHECK_EN
    logic [ADDR_W-1:0] prev_addr_q, prev_addr_d;
    logic              prev_vld_q, prev_vld_d;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] bnd_mask;
    logic [ADDR_W-1:0] seq_addr;
    logic [4:0]        beats;

    // SEQ beats of INCR bursts step by the size; WRAP bursts wrap inside beats*size.
    always_comb begin
        beats       = wrap_beats(hburst_e'(bus.hburst));
        incr        = ADDR_W'(1) << bus.hsize;
        bnd_mask    = (ADDR_W'(beats) << bus.hsize) - ADDR_W'(1);
        seq_addr    = prev_addr_q + incr;
        if (beats != 5'd0) begin
            seq_addr = (prev_addr_q & ~bnd_mask) | (seq_addr & bnd_mask);
        end
        burst_err   = prev_vld_q && (bus.htrans == HTRANS_SEQ) &&
                      (bus.hburst != HBURST_SINGLE) && (bus.haddr != seq_addr);
        prev_addr_d = prev_addr_q;
        prev_vld_d  = prev_vld_q;
        if (accept) begin
            prev_addr_d = bus.haddr;
            prev_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge hclk) begin
        if (hrst) begin
            prev_addr_q <= '0;
            prev_vld_q  <= 1'b0;
        end else begin
            prev_addr_q <= prev_addr_d;
            prev_vld_q  <= prev_vld_d;
        end
    end
`else
    logic unused_hburst;
    assign unused_hburst = ^bus.hburst;
    assign burst_err     = 1'b0;
`endif

    always_comb begin
        hready_int = 1'b1;
        hresp_int  = HRESP_OKAY;
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        strb_d     = strb_q;
        write_d    = write_q;

        case (state_q)
            ST_WAIT: begin
                hready_int = 1'b0;
                if (cnt_q == '0) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: begin
                hready_int = 1'b0;
                hresp_int  = HRESP_ERROR;
                state_d    = ST_ERR2;
            end
            ST_ERR2: begin
                hresp_int = HRESP_ERROR;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Acceptance only happens in hready-high states, so it overrides the defaults above.
        accept = hready_int && bus.htrans[1];
        if (accept) begin
            idx_d   = bus.haddr[IDX_W+1:2];
            strb_d  = strb;
            write_d = bus.hwrite;
            if (xfer_err) begin
                state_d = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d = ST_WAIT;
                cnt_d   = WS_LOAD;
            end else begin
                state_d = ST_DATA;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hrst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            strb_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            strb_q  <= strb_d;
            write_q <= write_d;
        end
    end

    // Contents survive reset; only a write data phase still live at this edge commits.
    always_ff @(posedge hclk) begin
        if (!hrst && (state_q == ST_DATA) && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (strb_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= bus.hwdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.hready = hready_int;
    assign bus.hresp  = hresp_int;
    assign bus.hrdata = ((state_q == ST_DATA) && !write_q) ? mem_q[idx_q] : '0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Scoreboard bench for ahb_slave_mem: one zero-wait and one three-wait instance.
module tb_ahb_slave_mem;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic        write;
    } xfer_t;

    typedef struct {
        logic        is_read;
        logic        err;
        logic [31:0] data;
        logic [31:0] wdata;
        int          waits;
    } exp_t;

    logic        hclk = 1'b0;
    logic        hrst = 1'b1;
    logic        sel  = 1'b0;
    logic [31:0] d_haddr  = '0;
    logic [31:0] d_hwdata = '0;
    logic [2:0]  d_hburst = '0;
    logic [2:0]  d_hsize  = '0;
    logic [1:0]  d_htrans = '0;
    logic        d_hwrite = 1'b0;
    logic        m_rdy;
    logic        m_resp;
    logic [31:0] m_rdata;

    int    n_cmp  = 0;
    int    n_fail = 0;
    string cur_test = "none";

    xfer_t xq[$];
    exp_t  sbq[$];
    logic [7:0] mem_m [2][1024];

`ifdef AHB_SLV_BURST_CHECK_EN
    logic [31:0] b_prev     = '0;
    logic        b_prev_vld = 1'b0;
`endif

    always #5 hclk = ~hclk;

    ahb_slave_mem_if #(.ADDR_W(32)) bus0 ();
    ahb_slave_mem_if #(.ADDR_W(32)) bus3 ();

    assign bus0.haddr  = d_haddr;
    assign bus0.hwdata = d_hwdata;
    assign bus0.hburst = d_hburst;
    assign bus0.hsize  = d_hsize;
    assign bus0.hwrite = d_hwrite;
    assign bus0.htrans = sel ? 2'd0 : d_htrans;
    assign bus3.haddr  = d_haddr;
    assign bus3.hwdata = d_hwdata;
    assign bus3.hburst = d_hburst;
    assign bus3.hsize  = d_hsize;
    assign bus3.hwrite = d_hwrite;
    assign bus3.htrans = sel ? d_htrans : 2'd0;

    assign m_rdy   = sel ? bus3.hready : bus0.hready;
    assign m_resp  = sel ? bus3.hresp  : bus0.hresp;
    assign m_rdata = sel ? bus3.hrdata : bus0.hrdata;

    ahb_slave_mem #(.MEM_BYTES(1024), .WAIT_STATES(0), .ADDR_W(32)) dut0 (
        .hclk (hclk),
        .hrst (hrst),
        .bus  (bus0.slave)
    );

    ahb_slave_mem #(.MEM_BYTES(1024), .WAIT_STATES(3), .ADDR_W(32)) dut3 (
        .hclk (hclk),
        .hrst (hrst),
        .bus  (bus3.slave)
    );

    function automatic logic base_err(input xfer_t x);
        return (x.addr >= 32'd1024) || (x.size > 3'd2) ||
               (x.size == 3'd1 && x.addr[0]) || (x.size == 3'd2 && x.addr[1:0] != 2'b00);
    endfunction

    function automatic bit lane_on(input logic [2:0] sz, input logic [1:0] a, input int i);
        case (sz)
            3'd0:    return i == int'(a);
            3'd1:    return (i / 2) == int'(a[1]);
            3'd2:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push_x(input logic [31:0] a, input logic [2:0] sz, input logic [1:0] tr,
                          input logic [2:0] bu, input logic wr, input logic [31:0] wd);
        xfer_t x;
        x.addr = a; x.size = sz; x.trans = tr; x.burst = bu; x.write = wr; x.wdata = wd;
        xq.push_back(x);
    endtask

    // Drives queued transfers as a pipelined master; expectations enter sbq at the address
    // phase and are popped when the matching data phase ends with hready high.
    task automatic run_seq(input int ws);
        xfer_t x;
        exp_t  e;
        logic  dp_act;
        int    waits;
        int    guard;
        int    m;
        dp_act = 1'b0;
        waits  = 0;
        guard  = 0;
        m      = sel ? 1 : 0;
        while ((xq.size() > 0 || dp_act) && guard < 400) begin
            @(negedge hclk);
            guard++;
            if (dp_act) begin
                d_hwdata = sbq[0].wdata;
                if (!m_rdy) begin
                    waits++;
                    n_cmp++;
                    if (m_resp !== sbq[0].err || m_rdata !== 32'h0) begin
                        n_fail++;
                        $display("FAIL %s wait-cycle: got resp=%b rdata=%h required resp=%b rdata=0",
                                 cur_test, m_resp, m_rdata, sbq[0].err);
                    end
                end else begin
                    e = sbq.pop_front();
                    dp_act = 1'b0;
                    n_cmp++;
                    if (waits !== e.waits) begin
                        n_fail++;
                        $display("FAIL %s wait-count: got %0d required %0d", cur_test, waits, e.waits);
                    end
                    n_cmp++;
                    if (m_resp !== e.err) begin
                        n_fail++;
                        $display("FAIL %s hresp: got %b required %b", cur_test, m_resp, e.err);
                    end
                    n_cmp++;
                    if (m_rdata !== ((e.is_read && !e.err) ? e.data : 32'h0)) begin
                        n_fail++;
                        $display("FAIL %s hrdata: got %h required %h", cur_test, m_rdata,
                                 (e.is_read && !e.err) ? e.data : 32'h0);
                    end
                end
            end else begin
                n_cmp++;
                if (m_rdy !== 1'b1 || m_resp !== 1'b0 || m_rdata !== 32'h0) begin
                    n_fail++;
                    $display("FAIL %s idle-cycle: got rdy=%b resp=%b rdata=%h required 1/0/0",
                             cur_test, m_rdy, m_resp, m_rdata);
                end
            end
            if (m_rdy) begin
                if (xq.size() > 0) begin
                    x = xq.pop_front();
                    d_haddr  = x.addr;
                    d_hsize  = x.size;
                    d_htrans = x.trans;
                    d_hburst = x.burst;
                    d_hwrite = x.write;
                    if (x.trans[1]) begin
                        e.is_read = !x.write;
                        e.err     = base_err(x);
`ifdef AHB_SLV_BURST_CHECK_EN
                        if (x.trans == 2'd3 && b_prev_vld && x.burst[0] &&
                            x.addr != b_prev + (32'd1 << x.size)) e.err = 1'b1;
                        b_prev     = x.addr;
                        b_prev_vld = 1'b1;
`endif
                        e.wdata = x.wdata;
                        e.waits = e.err ? 1 : ws;
                        e.data  = 32'h0;
                        if (!e.err) begin
                            for (int i = 0; i < 4; i++) begin
                                if (x.write && lane_on(x.size, x.addr[1:0], i))
                                    mem_m[m][{x.addr[9:2], 2'b00} + i] = x.wdata[8*i +: 8];
                                e.data[8*i +: 8] = mem_m[m][{x.addr[9:2], 2'b00} + i];
                            end
                        end
                        sbq.push_back(e);
                        dp_act = 1'b1;
                        waits  = 0;
                    end
                end else begin
                    d_htrans = 2'd0;
                end
            end
        end
        if (guard >= 400) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s timeout: got no data-phase completion required one within 400 cycles",
                     cur_test);
            xq.delete();
            sbq.delete();
            d_htrans = 2'd0;
        end
    endtask

    task automatic test_reset();
        cur_test = "reset";
        hrst = 1'b1;
        repeat (3) @(negedge hclk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            n_cmp++;
            if (m_rdy !== 1'b1 || m_resp !== 1'b0 || m_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset dut%0d: got rdy=%b resp=%b rdata=%h required 1/0/0",
                         s, m_rdy, m_resp, m_rdata);
            end
        end
        sel = 1'b0;
        @(negedge hclk);
        hrst = 1'b0;
    endtask

    task automatic test_word_rw();
        cur_test = "word_rw";
        sel = 1'b0;
        push_x(32'h10, 3'd2, 2'd2, 3'd0, 1'b1, 32'hDEADBEEF);
        push_x(32'h10, 3'd2, 2'd2, 3'd0, 1'b0, 32'h0);
        push_x(32'h14, 3'd2, 2'd2, 3'd0, 1'b1, 32'h11223344);
        push_x(32'h14, 3'd2, 2'd0, 3'd0, 1'b0, 32'h0);
        push_x(32'h14, 3'd2, 2'd2, 3'd0, 1'b0, 32'h0);
        run_seq(0);
    endtask

    task automatic test_byte_half();
        cur_test = "byte_half";
        sel = 1'b0;
        push_x(32'h0, 3'd2, 2'd2, 3'd0, 1'b1, 32'h00000000);
        push_x(32'h1, 3'd0, 2'd2, 3'd0, 1'b1, 32'h0000AA00);
        push_x(32'h2, 3'd1, 2'd2, 3'd0, 1'b1, 32'h12340000);
        push_x(32'h0, 3'd2, 2'd2, 3'd0, 1'b0, 32'h0);
        push_x(32'h3, 3'd0, 2'd2, 3'd0, 1'b0, 32'h0);
        run_seq(0);
    endtask

    task automatic test_wait_states();
        cur_test = "wait_states";
        sel = 1'b1;
        push_x(32'h20, 3'd2, 2'd2, 3'd0, 1'b1, 32'hA5A55A5A);
        push_x(32'h20, 3'd2, 2'd2, 3'd0, 1'b0, 32'h0);
        push_x(32'h23, 3'd0, 2'd2, 3'd0, 1'b1, 32'h7E000000);
        push_x(32'h20, 3'd2, 2'd2, 3'd0, 1'b0, 32'h0);
        run_seq(3);
    endtask

    task automatic test_errors();
        cur_test = "errors";
        sel = 1'b0;
        push_x(32'h400, 3'd2, 2'd2, 3'd0, 1'b0, 32'h0);
        push_x(32'h3,   3'd1, 2'd2, 3'd0, 1'b1, 32'hFFFFFFFF);
        push_x(32'h8,   3'd3, 2'd2, 3'd0, 1'b1, 32'hFFFFFFFF);
        push_x(32'h2,   3'd2, 2'd2, 3'd0, 1'b1, 32'hFFFFFFFF);
        push_x(32'h0,   3'd2, 2'd2, 3'd0, 1'b0, 32'h0);
        run_seq(0);
        cur_test = "errors_ws3";
        sel = 1'b1;
        push_x(32'h401, 3'd0, 2'd2, 3'd0, 1'b1, 32'h0000FF00);
        push_x(32'h20,  3'd2, 2'd2, 3'd0, 1'b0, 32'h0);
        run_seq(3);
    endtask

    task automatic test_back_to_back();
        cur_test = "burst";
        sel = 1'b0;
        for (int i = 0; i < 4; i++)
            push_x(32'h40 + 32'(4 * i), 3'd2, (i == 0) ? 2'd2 : 2'd3, 3'd3, 1'b1,
                   32'hC0DE0000 + 32'(i * 32'h111));
        push_x(32'h50, 3'd2, 2'd2, 3'd0, 1'b1, 32'h5050A0A0);
        push_x(32'h40, 3'd2, 2'd2, 3'd3, 1'b0, 32'h0);
        push_x(32'h44, 3'd2, 2'd3, 3'd3, 1'b0, 32'h0);
        push_x(32'h48, 3'd2, 2'd1, 3'd3, 1'b0, 32'h0);
        push_x(32'h48, 3'd2, 2'd3, 3'd3, 1'b0, 32'h0);
        push_x(32'h4C, 3'd2, 2'd3, 3'd3, 1'b0, 32'h0);
        push_x(32'h40, 3'd2, 2'd2, 3'd3, 1'b0, 32'h0);
        push_x(32'h44, 3'd2, 2'd3, 3'd3, 1'b0, 32'h0);
        push_x(32'h50, 3'd2, 2'd3, 3'd3, 1'b0, 32'h0);
        push_x(32'h50, 3'd2, 2'd2, 3'd0, 1'b0, 32'h0);
        run_seq(0);
    endtask

    task automatic test_reset_mid();
        cur_test = "reset_mid";
        sel = 1'b1;
        push_x(32'h30, 3'd2, 2'd2, 3'd0, 1'b1, 32'hCAFEF00D);
        run_seq(3);
        @(negedge hclk);
        d_haddr  = 32'h30;
        d_hsize  = 3'd2;
        d_hwrite = 1'b0;
        d_hburst = 3'd0;
        d_htrans = 2'd2;
        @(negedge hclk);
        n_cmp++;
        if (m_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid in-wait: got rdy=%b required 0", m_rdy);
        end
        hrst     = 1'b1;
        d_htrans = 2'd0;
        @(negedge hclk);
        n_cmp++;
        if (m_rdy !== 1'b1 || m_resp !== 1'b0 || m_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid after-reset: got rdy=%b resp=%b rdata=%h required 1/0/0",
                     m_rdy, m_resp, m_rdata);
        end
        hrst = 1'b0;
`ifdef AHB_SLV_BURST_CHECK_EN
        b_prev_vld = 1'b0;
`endif
        push_x(32'h30, 3'd2, 2'd2, 3'd0, 1'b0, 32'h0);
        push_x(32'h20, 3'd2, 2'd2, 3'd0, 1'b0, 32'h0);
        run_seq(3);
        cur_test = "reset_mid_ws0";
        sel = 1'b0;
        push_x(32'h10, 3'd2, 2'd2, 3'd0, 1'b0, 32'h0);
        run_seq(0);
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_half();
        test_wait_states();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge hclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running required completion by 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
